// File: rtl/csv_acc_stage.sv
// csv_acc_stage: accumulates a frame of unsigned operands into a carry-save
// (S, C) pair using one 3:2 compression per accepted beat. It presents the
// pair as XS/XC with an overflow flag through a valid/ready handshake.
// Optional build macro CSV_ACC_SKID_EN lets a new frame's first beat be
// accepted in the same cycle the previous result is handed off. Without it,
// one bubble cycle separates frames.
module csv_acc_stage #(
  parameter int widthX   = 8,
  parameter int widthA   = 8,
  parameter int maxBeats = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [widthA-1:0]            in_data_i,
  input  logic                         in_last_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [widthX-1:0]            XS_o,
  output logic [widthX-1:0]            XC_o,
  output logic                         out_ovf_o,
  output logic [$clog2(maxBeats+1)-1:0] out_beats_o
);

  localparam int CW = $clog2(maxBeats + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(maxBeats);

  typedef enum logic {ACC, HOLD} state_e;

  state_e            state_q, state_d;
  logic [widthX-1:0] s_q, s_d, c_q, c_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sticky_q, sticky_d, ovf_q, ovf_d;

  logic [widthX-1:0] a_ext, s_acc, c_acc, maj, wrap_sum;
  logic [CW-1:0]     cnt_inc;
  logic              sticky_acc, close_acc, carry_out;
  logic              in_accept, out_accept;

  // In HOLD, the skid build hands the input port to the downstream ready.
`ifdef CSV_ACC_SKID_EN
  assign in_ready_o = (state_q == ACC) ? 1'b1 : out_ready_i;
`else
  assign in_ready_o = (state_q == ACC);
`endif
  assign out_valid_o = (state_q == HOLD);
  assign in_accept   = in_valid_i & in_ready_o;
  assign out_accept  = out_valid_o & out_ready_i;

  assign XS_o        = s_q;
  assign XC_o        = c_q;
  assign out_ovf_o   = ovf_q;
  assign out_beats_o = cnt_q;

  // One 3:2 compression of (S, C, A), plus the close condition and the
  // carry-out of the resulting pair's full-width sum.
  always_comb begin
    a_ext      = widthX'(in_data_i);
    s_acc      = s_q ^ c_q ^ a_ext;
    maj        = (s_q & c_q) | (s_q & a_ext) | (c_q & a_ext);
    c_acc      = maj << 1;
    sticky_acc = sticky_q | maj[widthX-1];
    cnt_inc    = cnt_q + CW'(1);
    close_acc  = in_last_i | (cnt_inc == MAX_CNT);
    wrap_sum   = s_acc + c_acc;
    carry_out  = (wrap_sum < s_acc);
  end

  // Next-state logic for the ACC/HOLD controller and the accumulator datapath.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    case (state_q)
      ACC: begin
        if (in_accept) begin
          s_d      = s_acc;
          c_d      = c_acc;
          sticky_d = sticky_acc;
          cnt_d    = cnt_inc;
          if (close_acc) begin
            ovf_d   = sticky_acc | carry_out;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_accept) begin
          s_d      = '0;
          c_d      = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
          ovf_d    = 1'b0;
          state_d  = ACC;
`ifdef CSV_ACC_SKID_EN
          if (in_accept) begin
            s_d   = a_ext;
            cnt_d = CW'(1);
            if (in_last_i || (MAX_CNT == CW'(1))) begin
              state_d = HOLD;
            end
          end
`endif
        end
      end
      default: state_d = ACC;
    endcase
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ACC;
      s_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule
